// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering the core's data master port, with optional
// waitrequest wait states, sticky bad-access flag and saturating access counters.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_memory_addr,
  input  logic [31:0] data_memory_writedata,
  input  logic        data_memory_write_en,
  input  logic        data_memory_read_en,
  input  logic [3:0]  data_memory_byteenable,
  output logic [31:0] data_memory_readdata,
  output logic        data_memory_readdatavalid,
  output logic        data_memory_waitrequest,
  output logic        access_error,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e                  r_state, w_state_next;
  logic [3:0]              r_wait_cnt, w_wait_cnt_next, w_cnt_dec;
  logic [31:0]             r_mem [Depth];
  logic [31:0]             r_readdata;
  logic                    r_readdatavalid;
  logic                    r_access_error;
  logic [15:0]             r_read_count, r_write_count;
  logic                    w_req, w_do_access, w_waitreq, w_valid;
  logic [31:0]             w_offset;
  logic [ADDR_WIDTH-1:0]   w_index;

  assign w_req     = data_memory_write_en | data_memory_read_en;
  assign w_offset  = data_memory_addr - BASE_ADDR;
  // BASE_ADDR is word aligned, so the offset's low bits carry the address alignment.
  assign w_valid   = ((w_offset >> (ADDR_WIDTH + 2)) == 32'd0) && (w_offset[1:0] == 2'b00);
  assign w_index   = w_offset[ADDR_WIDTH+1:2];
  assign w_cnt_dec = r_wait_cnt - 4'd1;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_do_access     = 1'b0;
    w_waitreq       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_do_access = 1'b1;
          end else begin
            w_waitreq = 1'b1;
            if (WaitLoad == 4'd0) begin
              w_state_next = StAccess;
            end else begin
              w_state_next    = StWait;
              w_wait_cnt_next = WaitLoad;
            end
          end
        end
      end
      StWait: begin
        w_waitreq = 1'b1;
        if (!w_req) begin
          w_state_next = StIdle;
        end else begin
          w_wait_cnt_next = w_cnt_dec;
          if (w_cnt_dec == 4'd0) w_state_next = StAccess;
        end
      end
      StAccess: begin
        w_do_access  = w_req;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= StIdle;
      r_wait_cnt      <= 4'd0;
      r_readdata      <= 32'h0000_0000;
      r_readdatavalid <= 1'b0;
      r_access_error  <= 1'b0;
      r_read_count    <= 16'h0000;
      r_write_count   <= 16'h0000;
    end else begin
      r_state         <= w_state_next;
      r_wait_cnt      <= w_wait_cnt_next;
      r_readdatavalid <= 1'b0;
      if (w_do_access) begin
        if (!w_valid) r_access_error <= 1'b1;
        if (data_memory_read_en) begin
          r_readdatavalid <= 1'b1;
          r_readdata      <= w_valid ? r_mem[w_index] : 32'h0000_0000;
          if (r_read_count != 16'hFFFF) r_read_count <= r_read_count + 16'd1;
        end
        if (data_memory_write_en && (r_write_count != 16'hFFFF)) begin
          r_write_count <= r_write_count + 16'd1;
        end
      end
    end
  end

  // RAM is deliberately not cleared by reset; a read in the same access sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && w_do_access && data_memory_write_en && w_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (data_memory_byteenable[i]) begin
          r_mem[w_index][8*i +: 8] <= data_memory_writedata[8*i +: 8];
        end
      end
    end
  end

  assign data_memory_readdata      = r_readdata;
  assign data_memory_readdatavalid = r_readdatavalid;
  assign data_memory_waitrequest   = w_waitreq & ~reset;
  assign access_error              = r_access_error;
  assign read_count                = r_read_count;
  assign write_count               = r_write_count;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance without wait states,
// one with three wait states and a non-zero base address.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3;
  logic [31:0] a0, wd0, rd0, a3, wd3, rd3;
  logic        we0, re0, rdv0, wr0, err0;
  logic        we3, re3, rdv3, wr3, err3;
  logic [3:0]  be0, be3;
  logic [15:0] rc0, wc0, rc3, wc3;

  int n_checks = 0;
  int n_err    = 0;
  int exp_rc0 = 0, exp_wc0 = 0, exp_rc3 = 0, exp_wc3 = 0;
  logic [31:0] q0[$];
  logic [31:0] q3[$];

  data_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk(clk), .reset(rst0),
    .data_memory_addr(a0), .data_memory_writedata(wd0),
    .data_memory_write_en(we0), .data_memory_read_en(re0),
    .data_memory_byteenable(be0), .data_memory_readdata(rd0),
    .data_memory_readdatavalid(rdv0), .data_memory_waitrequest(wr0),
    .access_error(err0), .read_count(rc0), .write_count(wc0)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_dut3 (
    .clk(clk), .reset(rst3),
    .data_memory_addr(a3), .data_memory_writedata(wd3),
    .data_memory_write_en(we3), .data_memory_read_en(re3),
    .data_memory_byteenable(be3), .data_memory_readdata(rd3),
    .data_memory_readdatavalid(rdv3), .data_memory_waitrequest(wr3),
    .access_error(err3), .read_count(rc3), .write_count(wc3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > 65535) ? 32'h0000_FFFF : 32'(v);
  endfunction

  // Monitors: every readdatavalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rdv0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut0 readdatavalid: got pulse with data %h, expected none", rd0);
      end else check("dut0 readdata", rd0, q0.pop_front());
    end
    if (rdv3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL dut3 readdatavalid: got pulse with data %h, expected none", rd3);
      end else check("dut3 readdata", rd3, q3.pop_front());
    end
  end

  task automatic d0_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    we0 = w; re0 = r; a0 = a; wd0 = d; be0 = b;
    exp_wc0 += int'(w); exp_rc0 += int'(r);
    @(posedge clk); #1;
    we0 = 1'b0; re0 = 1'b0;
  endtask

  task automatic d0_idle(input int n);
    we0 = 1'b0; re0 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic d3_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, output int cyc);
    logic done;
    we3 = w; re3 = r; a3 = a; wd3 = d; be3 = b;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk); done = ~wr3;
      @(posedge clk); #1;
      cyc++;
    end
    we3 = 1'b0; re3 = 1'b0;
    if (done) begin
      exp_wc3 += int'(w); exp_rc3 += int'(r);
    end else begin
      n_checks++; n_err++;
      $display("FAIL dut3 handshake: got waitrequest high for %0d cycles, expected release", cyc);
    end
  endtask

  task automatic d3_idle(input int n);
    we3 = 1'b0; re3 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst0 = 1'b1; rst3 = 1'b1;
    we0 = 1'b0; re0 = 1'b0; a0 = '0; wd0 = '0; be0 = 4'hF;
    we3 = 1'b1; re3 = 1'b0; a3 = 32'h0000_1000; wd3 = '0; be3 = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dut0 reset readdata", rd0, 32'h0);
    check("dut0 reset readdatavalid", 32'(rdv0), 32'd0);
    check("dut0 reset error", 32'(err0), 32'd0);
    check("dut0 reset counts", {rc0, wc0}, 32'h0);
    check("dut3 waitrequest low in reset", 32'(wr3), 32'd0);
    check("dut3 reset counts", {rc3, wc3}, 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0; we3 = 1'b0;

    // Zero wait states: write then read back.
    d0_req(1, 0, 32'h10, 32'hCAFE_F00D, 4'hF);
    q0.push_back(32'hCAFE_F00D);
    d0_req(0, 1, 32'h10, 32'h0, 4'hF);
    check("dut0 readdatavalid after read", 32'(rdv0), 32'd1);
    d0_idle(2);
    check("dut0 write_count", 32'(wc0), sat(exp_wc0));
    check("dut0 read_count", 32'(rc0), sat(exp_rc0));
    check("dut0 waitrequest", 32'(wr0), 32'd0);

    // Partial byte-lane write.
    d0_req(1, 0, 32'h20, 32'h1122_3344, 4'hF);
    d0_req(1, 0, 32'h20, 32'hAABB_CCDD, 4'b0101);
    q0.push_back(32'h11BB_33DD);
    d0_req(0, 1, 32'h20, 32'h0, 4'hF);
    d0_idle(1);

    // Readdata holds across idle and write cycles.
    q0.push_back(32'hCAFE_F00D);
    d0_req(0, 1, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("dut0 hold readdata", rd0, 32'hCAFE_F00D);
      if (i > 0) check("dut0 hold readdatavalid", 32'(rdv0), 32'd0);
      @(posedge clk); #1;
    end
    d0_req(1, 0, 32'h24, 32'h0BAD_CAFE, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dut0 hold after write", rd0, 32'hCAFE_F00D);
      check("dut0 no valid after write", 32'(rdv0), 32'd0);
      @(posedge clk); #1;
    end

    // Misaligned read and out-of-range write.
    check("dut0 error clear before bad access", 32'(err0), 32'd0);
    q0.push_back(32'h0);
    d0_req(0, 1, 32'h2, 32'h0, 4'hF);
    d0_idle(1);
    check("dut0 error after misaligned", 32'(err0), 32'd1);
    d0_req(1, 0, 32'h0, 32'h1234_5678, 4'hF);
    d0_req(1, 0, 32'h4000, 32'hDEAD_BEEF, 4'hF);
    q0.push_back(32'h1234_5678);
    d0_req(0, 1, 32'h0, 32'h0, 4'hF);
    d0_idle(2);
    check("dut0 error sticky", 32'(err0), 32'd1);

    // Simultaneous read and write returns the old word.
    d0_req(1, 0, 32'h30, 32'h5, 4'hF);
    q0.push_back(32'h5);
    d0_req(1, 1, 32'h30, 32'h9, 4'hF);
    q0.push_back(32'h9);
    d0_req(0, 1, 32'h30, 32'h0, 4'hF);
    d0_idle(2);
    check("dut0 write_count mixed", 32'(wc0), sat(exp_wc0));
    check("dut0 read_count mixed", 32'(rc0), sat(exp_rc0));

    // Three wait states, base 0x1000.
    d3_req(1, 0, 32'h1010, 32'hAAAA_5555, 4'hF, cyc);
    check("dut3 write occupancy", 32'(cyc), 32'd4);
    re3 = 1'b1; a3 = 32'h1010;
    q3.push_back(32'hAAAA_5555);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dut3 waitrequest cycle", 32'(wr3), 32'(i < 3));
      @(posedge clk); #1;
    end
    re3 = 1'b0; exp_rc3++;
    @(negedge clk);
    check("dut3 readdatavalid on cycle 4", 32'(rdv3), 32'd1);
    @(posedge clk); #1;

    // Reset during the first wait cycle of a write.
    we3 = 1'b1; a3 = 32'h1010; wd3 = 32'h0; be3 = 4'hF;
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(negedge clk);
    check("dut3 waitrequest forced low", 32'(wr3), 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0; we3 = 1'b0; exp_rc3 = 0; exp_wc3 = 0;
    @(negedge clk);
    check("dut3 post-reset readdata", rd3, 32'h0);
    check("dut3 post-reset readdatavalid", 32'(rdv3), 32'd0);
    check("dut3 post-reset waitrequest", 32'(wr3), 32'd0);
    check("dut3 post-reset counts", {rc3, wc3}, 32'h0);
    @(posedge clk); #1;
    q3.push_back(32'hAAAA_5555);
    d3_req(0, 1, 32'h1010, 32'h0, 4'hF, cyc);

    // Read dropped mid-wait: no access, no count.
    re3 = 1'b1; a3 = 32'h1010;
    repeat (2) begin @(posedge clk); #1; end
    d3_idle(6);
    check("dut3 read_count after abort", 32'(rc3), sat(exp_rc3));
    check("dut3 error before bad access", 32'(err3), 32'd0);

    // Below-base and past-end accesses.
    q3.push_back(32'h0);
    d3_req(0, 1, 32'h0FFC, 32'h0, 4'hF, cyc);
    d3_idle(1);
    check("dut3 error below base", 32'(err3), 32'd1);
    d3_req(1, 0, 32'h1000, 32'h77, 4'hF, cyc);
    d3_req(1, 0, 32'h1400, 32'hDEAD_BEEF, 4'hF, cyc);
    q3.push_back(32'h77);
    d3_req(0, 1, 32'h1000, 32'h0, 4'hF, cyc);
    q3.push_back(32'h0);
    d3_req(0, 1, 32'h1400, 32'h0, 4'hF, cyc);
    d3_idle(2);
    check("dut3 write_count", 32'(wc3), sat(exp_wc3));
    check("dut3 read_count", 32'(rc3), sat(exp_rc3));

    // Write counter saturation.
    we0 = 1'b1; a0 = 32'h40; be0 = 4'hF;
    for (int i = 0; i < 66000; i++) begin
      wd0 = 32'(i);
      @(posedge clk); #1;
      exp_wc0++;
    end
    d0_idle(2);
    check("dut0 write_count saturated", 32'(wc0), sat(exp_wc0));
    check("dut0 read_count after burst", 32'(rc0), sat(exp_rc0));
    check("dut0 error still set", 32'(err0), 32'd1);

    // Reset clears flags and counters but not RAM.
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; exp_wc0 = 0; exp_rc0 = 0;
    @(negedge clk);
    check("dut0 error cleared", 32'(err0), 32'd0);
    check("dut0 counts cleared", {rc0, wc0}, 32'h0);
    @(posedge clk); #1;
    q0.push_back(32'h9);
    d0_req(0, 1, 32'h30, 32'h0, 4'hF);
    d0_idle(3);

    check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    check("dut3 scoreboard drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
